instr_queue: RTL and testbench

Instruction queue between the fetch stage and decode. It holds {instruction, PC+2} pairs produced by fetch and presents them to decode through a valid/ready handshake. Fetch keeps running while decode is stalled by the hazard unit. The queue also absorbs branch flushes and latches HALT so fetch stops issuing past it.

---
 rtl/instr_queue_pkg.sv | 18 +
 rtl/instr_queue_iq_storage.sv | 26 ++
 rtl/instr_queue.sv | 121 ++++++++++++
 tb/tb_instr_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_queue_pkg.sv
// Shared fetch/decode constants and the queue entry layout.
package instr_queue_pkg;

    localparam logic [15:0] NOP_INSTR_C = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam int          OPC_MSB     = 15;
    localparam int          OPC_LSB     = 11;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcinc;
    } iq_entry_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instr_queue_iq_storage.sv
// Entry storage for instr_queue: one write port, one asynchronous read port.
module iq_storage #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // NOTE: no reset on the array; entry validity is tracked by the occupancy
    // counter, so clearing the contents would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue with flush and HALT latching.
// Define IQ_BYPASS_EN to forward the fetch word straight to decode when empty.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_valid,
    input  logic [15:0]              f_instr,
    input  logic [15:0]              f_pcinc,
    output logic                     f_ready,
    output logic                     d_valid,
    output logic [15:0]              d_instr,
    output logic [15:0]              d_pcinc,
    input  logic                     d_ready,
    input  logic                     flush,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halted_q, halted_d;

    logic          push;
    logic          bypass;
    logic          wr_en;
    logic          pop_store;
    logic [31:0]   rd_data;
    iq_entry_t     head;

    iq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data ({f_instr, f_pcinc}),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign head = iq_entry_t'(rd_data);

    // A full queue stays closed even if decode pops this cycle, keeping
    // f_ready free of any d_ready path.
    assign f_ready = (count_q < CW'(DEPTH)) & ~halted_q & ~flush;
    assign push    = f_valid & f_ready;

    // NOTE: every signal driven here gets a default first so no latch can form.
    always_comb begin
        bypass = 1'b0;
`ifdef IQ_BYPASS_EN
        bypass = (count_q == '0) & push & d_ready;
`endif
        d_valid = (count_q != '0) | bypass;
        if (bypass) begin
            d_instr = f_instr;
            d_pcinc = f_pcinc;
        end else if (count_q != '0) begin
            d_instr = head.instr;
            d_pcinc = head.pcinc;
        end else begin
            d_instr = NOP_INSTR;
            d_pcinc = 16'h0000;
        end
    end

    assign wr_en     = push & ~bypass;
    assign pop_store = (count_q != '0) & d_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_store) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(wr_en) - CW'(pop_store);
            // A bypassed HALT still stops fetch.
            if (push && is_halt(f_instr)) begin
                halted_d = 1'b1;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
    assign count  = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH=4), either build of IQ_BYPASS_EN.
module tb_instr_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic [15:0] f_instr;
    logic [15:0] f_pcinc;
    logic        f_ready;
    logic        d_valid;
    logic [15:0] d_instr;
    logic [15:0] d_pcinc;
    logic        d_ready;
    logic        flush;
    logic        halted;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fails  = 0;

    instr_queue #(.DEPTH(4), .NOP_INSTR(16'h0800)) dut (
        .clk     (clk),
        .rst     (rst),
        .f_valid (f_valid),
        .f_instr (f_instr),
        .f_pcinc (f_pcinc),
        .f_ready (f_ready),
        .d_valid (d_valid),
        .d_instr (d_instr),
        .d_pcinc (d_pcinc),
        .d_ready (d_ready),
        .flush   (flush),
        .halted  (halted),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Streams n words through the queue with decode stalled for the first
    // `hold` cycles, checking order and occupancy against a small model.
    task automatic run_stream(input logic [15:0] base, input int n, input int hold);
        int wi = 0;
        int rcv = 0;
        int mcount = 0;
        logic push_m, pop_m, byp_m, dv_m;
        for (int cyc = 0; cyc < 64 && rcv < n; cyc++) begin
            d_ready = (cyc >= hold);
            f_valid = (wi < n);
            f_instr = 16'(base + wi);
            f_pcinc = 16'(16'h0200 + 2 * wi);
            #1;
            check("stream_count", 32'(count), 32'(mcount));
            check("stream_f_ready", 32'(f_ready), 32'(mcount < 4));
            push_m = f_valid && (mcount < 4);
            byp_m  = 1'b0;
`ifdef IQ_BYPASS_EN
            byp_m  = (mcount == 0) && push_m && d_ready;
`endif
            dv_m  = (mcount > 0) || byp_m;
            pop_m = d_ready && (mcount > 0);
            check("stream_d_valid", 32'(d_valid), 32'(dv_m));
            if (dv_m) begin
                check("stream_d_instr", 32'(d_instr), 32'(16'(base + rcv)));
                check("stream_d_pcinc", 32'(d_pcinc), 32'(16'(16'h0200 + 2 * rcv)));
                if (d_ready) rcv++;
            end
            mcount = mcount + int'(push_m && !byp_m) - int'(pop_m);
            if (push_m) wi++;
            tick();
        end
        check("stream_all_received", 32'(rcv), 32'(n));
        f_valid = 1'b0;
        d_ready = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        f_valid = 1'b0;
        f_instr = 16'h0000;
        f_pcinc = 16'h0000;
        d_ready = 1'b0;
        flush   = 1'b0;
        #13;
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_d_instr", 32'(d_instr), 32'h0800);
        check("rst_d_pcinc", 32'(d_pcinc), 32'h0000);
        check("rst_count", 32'(count), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst = 1'b1;
        tick();
        check("idle_f_ready", 32'(f_ready), 32'd1);
        check("idle_d_instr", 32'(d_instr), 32'h0800);

        // Fill to DEPTH with decode stalled; fifth word held, then drained in order.
        run_stream(16'h1001, 5, 5);

        // Steady push+pop at occupancy 2 for 10 cycles, pointers wrap.
        run_stream(16'h6001, 12, 2);

        // Flush at count=3 with a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'b1;
            f_instr = 16'(16'h5001 + i);
            f_pcinc = 16'h0300;
            tick();
        end
        f_instr = 16'h2222;
        flush   = 1'b1;
        #1;
        check("flush_pre_count", 32'(count), 32'd3);
        check("flush_f_ready_low", 32'(f_ready), 32'd0);
        tick();
        flush   = 1'b0;
        f_valid = 1'b0;
        d_ready = 1'b1;
        #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_d_valid", 32'(d_valid), 32'd0);
        check("flush_d_instr", 32'(d_instr), 32'h0800);
        check("flush_f_ready_back", 32'(f_ready), 32'd1);
        tick();
        check("flush_no_2222", 32'(d_valid), 32'd0);
        d_ready = 1'b0;

        // HALT followed by a rejected word, HALT delivered, then cleared by flush.
        f_valid = 1'b1;
        f_instr = 16'h0000;
        f_pcinc = 16'h0010;
        tick();
        f_instr = 16'h3333;
        f_pcinc = 16'h0012;
        #1;
        check("halt_set", 32'(halted), 32'd1);
        check("halt_f_ready", 32'(f_ready), 32'd0);
        tick();
        f_valid = 1'b0;
        check("halt_rejects", 32'(count), 32'd1);
        d_ready = 1'b1;
        #1;
        check("halt_d_valid", 32'(d_valid), 32'd1);
        check("halt_d_instr", 32'(d_instr), 32'h0000);
        check("halt_d_pcinc", 32'(d_pcinc), 32'h0010);
        tick();
        d_ready = 1'b0;
        check("halt_drained", 32'(count), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("halt_cleared", 32'(halted), 32'd0);
        check("halt_f_ready_back", 32'(f_ready), 32'd1);

        // Empty queue with decode ready: bypass build forwards the same cycle.
        f_valid = 1'b1;
        f_instr = 16'h4444;
        f_pcinc = 16'h0046;
        d_ready = 1'b1;
        #1;
`ifdef IQ_BYPASS_EN
        check("byp_d_valid", 32'(d_valid), 32'd1);
        check("byp_d_instr", 32'(d_instr), 32'h4444);
        check("byp_d_pcinc", 32'(d_pcinc), 32'h0046);
        tick();
        f_valid = 1'b0;
        #1;
        check("byp_count", 32'(count), 32'd0);
        check("byp_after", 32'(d_valid), 32'd0);
`else
        check("nobyp_d_valid", 32'(d_valid), 32'd0);
        check("nobyp_d_instr", 32'(d_instr), 32'h0800);
        tick();
        f_valid = 1'b0;
        #1;
        check("nobyp_count", 32'(count), 32'd1);
        check("nobyp_d_instr_next", 32'(d_instr), 32'h4444);
        check("nobyp_d_pcinc_next", 32'(d_pcinc), 32'h0046);
        tick();
        check("nobyp_drained", 32'(count), 32'd0);
`endif
        d_ready = 1'b0;

        // Asynchronous reset mid-operation clears state without an edge.
        f_valid = 1'b1;
        f_instr = 16'h7777;
        tick();
        f_valid = 1'b0;
        check("arst_pre_count", 32'(count), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_d_instr", 32'(d_instr), 32'h0800);
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
